// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart transmitter between NR_REQ byte sources.
// A grant is held for a whole message: until the EOM character is sent or the lock idles out.
module uart_tx_arb #(
    parameter int                 NR_BITS      = 8,
    parameter int                 NR_REQ       = 4,
    parameter logic [NR_BITS-1:0] EOM_CHAR     = NR_BITS'(8'h0A),
    parameter int                 LOCK_TIMEOUT = 1000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NR_REQ*NR_BITS-1:0] req_tx_d,
    input  logic [NR_REQ-1:0]         req_tx_dv,
    output logic [NR_REQ-1:0]         req_tx_dr,
    output logic [NR_REQ-1:0]         grant,
    output logic [NR_BITS-1:0]        uart_tx_d,
    output logic                      uart_tx_dv,
    input  logic                      uart_tx_dr,
    output logic                      timeout_evt
);

    localparam int IDX_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
    localparam int CND_W = IDX_W + 1;
    localparam int CNT_W = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam bit TO_EN = (LOCK_TIMEOUT > 0);

    localparam logic [CND_W-1:0]  CAND_WRAP = CND_W'(NR_REQ);
    localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(LOCK_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [NR_REQ-1:0] GRANT_ONE = {{(NR_REQ-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]  LAST_RST  = IDX_W'(NR_REQ - 1);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [NR_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                timeout_evt_q, timeout_evt_d;

    logic                arb_found;
    logic [IDX_W-1:0]    arb_idx;
    logic [CND_W-1:0]    cand;
    logic                xfer;
    logic                is_eom;
    logic [CNT_W-1:0]    cnt_sat;
    logic                timeout_hit;

    // Forwarding is purely combinational from the registered grant; no buffering.
    always_comb begin
        uart_tx_d  = '0;
        uart_tx_dv = 1'b0;
        req_tx_dr  = '0;
        for (int i = 0; i < NR_REQ; i++) begin
            if (grant_q[i]) begin
                uart_tx_d    = req_tx_d[i*NR_BITS +: NR_BITS];
                uart_tx_dv   = req_tx_dv[i];
                req_tx_dr[i] = uart_tx_dr;
            end
        end
    end

    assign xfer   = uart_tx_dv && uart_tx_dr;
    assign is_eom = (uart_tx_d == EOM_CHAR);

    // Scan from last+1 with wrap so the previous owner is considered last.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = last_q;
        cand      = '0;
        for (int j = 0; j < NR_REQ; j++) begin
            cand = {1'b0, last_q} + CND_W'(j + 1);
            if (cand >= CAND_WRAP) begin
                cand = cand - CAND_WRAP;
            end
            if (!arb_found && req_tx_dv[cand[IDX_W-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand[IDX_W-1:0];
            end
        end
    end

    assign cnt_sat     = (cnt_q == '1) ? cnt_q : (cnt_q + CNT_ONE);
    assign timeout_hit = TO_EN && (cnt_sat == CNT_LIMIT);

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        timeout_evt_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (arb_found) begin
                    state_d = LOCK;
                    grant_d = GRANT_ONE << arb_idx;
                    last_d  = arb_idx;
                end
            end
            LOCK: begin
                // A transfer wins over an expiring timer on the same edge.
                if (xfer) begin
                    cnt_d = '0;
                    if (is_eom) begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else if (timeout_hit) begin
                    state_d       = IDLE;
                    grant_d       = '0;
                    cnt_d         = '0;
                    timeout_evt_d = 1'b1;
                end else begin
                    cnt_d = cnt_sat;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            last_q        <= LAST_RST;
            cnt_q         <= '0;
            timeout_evt_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            timeout_evt_q <= timeout_evt_d;
        end
    end

    assign grant       = grant_q;
    assign timeout_evt = timeout_evt_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: directed scenarios plus randomized message traffic scored
// against a message-level round-robin model.
`timescale 1ns/1ps
module tb_uart_tx_arb;

    localparam int         NB  = 8;
    localparam int         NR  = 4;
    localparam logic [7:0] EOM = 8'h0A;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR*NB-1:0] req_tx_d;
    logic [NR-1:0]    req_tx_dv;
    logic             uart_tx_dr;

    logic [NR-1:0]    a_req_tx_dr, a_grant, b_req_tx_dr, b_grant;
    logic [NB-1:0]    a_uart_tx_d, b_uart_tx_d;
    logic             a_uart_tx_dv, b_uart_tx_dv, a_timeout_evt, b_timeout_evt;

    int n_tests = 0;
    int n_fail  = 0;

    // Traffic sources, scoreboard and grant trace.
    logic [NB-1:0] src_q [NR][$];
    logic [NB-1:0] exp_q [$];
    int            exp_own_q [$];
    logic [NR-1:0] gtrace_q [$];
    logic [NR-1:0] exp_gtrace_q [$];
    logic [NR-1:0] prev_grant;
    int            gap_cnt [NR];
    int            busy_cnt;
    int            max_busy;
    bit            gap_en;
    int            model_last;

    always #5 clk = ~clk;

    uart_tx_arb #(.NR_BITS(NB), .NR_REQ(NR), .EOM_CHAR(8'h0A), .LOCK_TIMEOUT(50)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_tx_d(req_tx_d), .req_tx_dv(req_tx_dv),
        .req_tx_dr(a_req_tx_dr), .grant(a_grant), .uart_tx_d(a_uart_tx_d),
        .uart_tx_dv(a_uart_tx_dv), .uart_tx_dr(uart_tx_dr), .timeout_evt(a_timeout_evt)
    );

    uart_tx_arb #(.NR_BITS(NB), .NR_REQ(NR), .EOM_CHAR(8'h0A), .LOCK_TIMEOUT(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_tx_d(req_tx_d), .req_tx_dv(req_tx_dv),
        .req_tx_dr(b_req_tx_dr), .grant(b_grant), .uart_tx_d(b_uart_tx_d),
        .uart_tx_dv(b_uart_tx_dv), .uart_tx_dr(uart_tx_dr), .timeout_evt(b_timeout_evt)
    );

    // ---------------- clock/reset ----------------
    task automatic do_reset();
        rst_n      = 1'b0;
        req_tx_dv  = '0;
        req_tx_d   = '0;
        uart_tx_dr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < NR; i++) begin
            src_q[i].delete();
            gap_cnt[i] = 0;
        end
        exp_q.delete();
        exp_own_q.delete();
        gtrace_q.delete();
        exp_gtrace_q.delete();
        prev_grant = '0;
        busy_cnt   = 0;
        model_last = NR - 1;
    endtask

    // ---------------- reference model ----------------
    // Message-level round robin: each pending message goes to the next requester
    // after the previous owner that still has messages queued.
    task automatic build_expected();
        logic [NB-1:0] mq [NR][$];
        logic [NB-1:0] b;
        logic [NR-1:0] oh;
        int pick;
        for (int i = 0; i < NR; i++) mq[i] = src_q[i];
        forever begin
            pick = -1;
            for (int k = 1; k <= NR; k++) begin
                if (pick < 0 && mq[(model_last + k) % NR].size() > 0) pick = (model_last + k) % NR;
            end
            if (pick < 0) break;
            model_last = pick;
            oh = 4'b0001 << pick;
            exp_gtrace_q.push_back(oh);
            exp_gtrace_q.push_back('0);
            do begin
                b = mq[pick].pop_front();
                exp_q.push_back(b);
                exp_own_q.push_back(pick);
            end while (b != EOM && mq[pick].size() > 0);
        end
    endtask

    function automatic bit trace_match();
        if (gtrace_q.size() != exp_gtrace_q.size()) return 1'b0;
        foreach (gtrace_q[i]) if (gtrace_q[i] !== exp_gtrace_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic gen_msg(input int i);
        int n;
        logic [NB-1:0] b;
        n = $urandom_range(1, 4);
        for (int j = 0; j < n; j++) begin
            b = 8'($urandom_range(0, 255));
            if (b == EOM) b = 8'h5A;
            src_q[i].push_back(b);
        end
        src_q[i].push_back(EOM);
    endtask

    // ---------------- driver + per-cycle scoreboard ----------------
    task automatic run_cycle();
        logic [NB-1:0] b;
        logic [NB-1:0] popped;
        logic [NR-1:0] oh;
        int own;
        for (int i = 0; i < NR; i++) begin
            if (src_q[i].size() > 0 && gap_cnt[i] == 0) begin
                req_tx_dv[i]          = 1'b1;
                req_tx_d[i*NB +: NB]  = src_q[i][0];
            end else begin
                req_tx_dv[i]          = 1'b0;
                req_tx_d[i*NB +: NB]  = 8'($urandom_range(0, 255));
            end
            if (gap_cnt[i] > 0) gap_cnt[i]--;
        end
        uart_tx_dr = (busy_cnt == 0);
        if (busy_cnt > 0) busy_cnt--;
        #4;
        n_tests++;
        if ((a_grant & (a_grant - 4'd1)) !== 4'd0) begin
            n_fail++;
            $display("FAIL grant_onehot: got %b required one-hot or zero", a_grant);
        end
        n_tests++;
        if ((a_req_tx_dr & ~a_grant) !== 4'd0) begin
            n_fail++;
            $display("FAIL dr_isolation: req_tx_dr %b with grant %b", a_req_tx_dr, a_grant);
        end
        n_tests++;
        if (a_uart_tx_dv !== |(req_tx_dv & a_grant)) begin
            n_fail++;
            $display("FAIL dv_isolation: uart_tx_dv %b required %b", a_uart_tx_dv, |(req_tx_dv & a_grant));
        end
        if (a_grant !== prev_grant) begin
            gtrace_q.push_back(a_grant);
            prev_grant = a_grant;
        end
        if (a_uart_tx_dv === 1'b1 && uart_tx_dr === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL extra_byte: got %h from grant %b, none expected", a_uart_tx_d, a_grant);
            end else begin
                b   = exp_q.pop_front();
                own = exp_own_q.pop_front();
                oh  = 4'b0001 << own;
                if (a_uart_tx_d !== b || a_grant !== oh) begin
                    n_fail++;
                    $display("FAIL byte_order: got %h grant %b required %h grant %b", a_uart_tx_d, a_grant, b, oh);
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (req_tx_dv[i] && a_req_tx_dr[i] && src_q[i].size() > 0) begin
                    popped = src_q[i].pop_front();
                    if (gap_en && popped != EOM && $urandom_range(0, 3) == 0) gap_cnt[i] = $urandom_range(1, 5);
                end
            end
            busy_cnt = $urandom_range(0, max_busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_traffic(input int budget, input string name);
        int cyc = 0;
        while (exp_q.size() > 0 && cyc < budget) begin
            run_cycle();
            cyc++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_budget: %0d bytes outstanding, required 0", name, exp_q.size());
        end
        run_cycle();
        run_cycle();
        n_tests++;
        if (!trace_match()) begin
            n_fail++;
            $display("FAIL %s_grant_trace: got %0d grant changes, required %0d", name, gtrace_q.size(), exp_gtrace_q.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n      = 1'b0;
        req_tx_dv  = '1;
        req_tx_d   = 32'hA5A5_0A0A;
        uart_tx_dr = 1'b1;
        repeat (2) @(posedge clk);
        #5;
        n_tests++;
        if (a_grant !== 4'd0 || b_grant !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_grant: got %b/%b required 0000", a_grant, b_grant);
        end
        n_tests++;
        if (a_uart_tx_dv !== 1'b0 || a_uart_tx_d !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_uart: dv %b d %h required 0 00", a_uart_tx_dv, a_uart_tx_d);
        end
        n_tests++;
        if (a_req_tx_dr !== 4'd0 || a_timeout_evt !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_dr_evt: dr %b evt %b required 0000 0", a_req_tx_dr, a_timeout_evt);
        end
        @(posedge clk);
        #1;
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        max_busy = 3;
        gap_en   = 1'b0;
        src_q[1] = '{8'h48, 8'h69, 8'h0A};
        build_expected();
        run_traffic(200, "single");
        n_tests++;
        if (a_grant !== 4'd0) begin
            n_fail++;
            $display("FAIL single_release: grant %b required 0000", a_grant);
        end
    endtask

    task automatic test_contention();
        do_reset();
        max_busy = 2;
        gap_en   = 1'b0;
        src_q[0] = '{8'h31, 8'h32, 8'h0A};
        src_q[2] = '{8'h41, 8'h42, 8'h0A};
        build_expected();
        run_traffic(200, "contention");
    endtask

    task automatic test_round_robin();
        do_reset();
        max_busy = 1;
        gap_en   = 1'b0;
        for (int i = 0; i < NR; i++) src_q[i] = '{8'h41, 8'h0A, 8'h41, 8'h0A};
        build_expected();
        run_traffic(400, "round_robin");
    endtask

    task automatic test_random();
        do_reset();
        max_busy = 3;
        gap_en   = 1'b1;
        for (int it = 0; it < 8; it++) begin
            gtrace_q.delete();
            exp_gtrace_q.delete();
            for (int i = 0; i < NR; i++) begin
                int nm;
                nm = $urandom_range(0, 3);
                for (int m = 0; m < nm; m++) gen_msg(i);
            end
            build_expected();
            run_traffic(3000, "random");
        end
    endtask

    task automatic test_timeout();
        bit found = 1'b0;
        bit exp_evt;
        logic [NR-1:0] exp_grant;
        do_reset();
        req_tx_d[3*NB +: NB] = 8'h55;
        req_tx_dv            = 4'b1000;
        uart_tx_dr           = 1'b1;
        for (int c = 0; c < 10 && !found; c++) begin
            #4;
            if (a_uart_tx_dv === 1'b1 && a_grant === 4'b1000) found = 1'b1;
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL timeout_first_xfer: no transfer from requester 3 within 10 cycles");
        end
        req_tx_dv            = 4'b0010;
        req_tx_d[1*NB +: NB] = 8'h77;
        for (int k = 1; k <= 52; k++) begin
            exp_evt   = (k == 51);
            exp_grant = (k <= 50) ? 4'b1000 : ((k == 51) ? 4'b0000 : 4'b0010);
            #4;
            n_tests++;
            if (a_timeout_evt !== exp_evt || a_grant !== exp_grant) begin
                n_fail++;
                $display("FAIL timeout_k%0d: evt %b grant %b required evt %b grant %b", k, a_timeout_evt, a_grant, exp_evt, exp_grant);
            end
            @(posedge clk);
            #1;
        end
        req_tx_dv = '0;
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        do_reset();
        req_tx_d[0 +: NB] = 8'h11;
        req_tx_dv         = 4'b0001;
        uart_tx_dr        = 1'b1;
        for (int c = 0; c < 10 && !found; c++) begin
            #4;
            if (a_uart_tx_dv === 1'b1 && a_uart_tx_d === 8'h11) found = 1'b1;
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL rstmid_first_xfer: byte 11 not transferred within 10 cycles");
        end
        req_tx_d[0 +: NB] = 8'h22;
        uart_tx_dr        = 1'b0;
        rst_n             = 1'b0;
        #4;
        n_tests++;
        if (a_grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL rstmid_locked: grant %b required 0001", a_grant);
        end
        @(posedge clk);
        #1;
        rst_n                = 1'b1;
        req_tx_d[2*NB +: NB] = 8'h99;
        req_tx_dv            = 4'b0101;
        uart_tx_dr           = 1'b1;
        #4;
        n_tests++;
        if (a_grant !== 4'd0 || a_uart_tx_dv !== 1'b0 || a_req_tx_dr !== 4'd0) begin
            n_fail++;
            $display("FAIL rstmid_cleared: grant %b dv %b dr %b required 0000 0 0000", a_grant, a_uart_tx_dv, a_req_tx_dr);
        end
        @(posedge clk);
        #1;
        #4;
        n_tests++;
        if (a_grant !== 4'b0001 || a_uart_tx_d !== 8'h22) begin
            n_fail++;
            $display("FAIL rstmid_rearb: grant %b d %h required 0001 22", a_grant, a_uart_tx_d);
        end
        @(posedge clk);
        #1;
        req_tx_dv = '0;
    endtask

    task automatic test_stall();
        bit found = 1'b0;
        do_reset();
        req_tx_d[2*NB +: NB] = 8'hA5;
        req_tx_dv            = 4'b0100;
        uart_tx_dr           = 1'b0;
        for (int c = 0; c < 8 && !found; c++) begin
            #4;
            if (b_grant === 4'b0100) found = 1'b1;
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL stall_grant: requester 2 not granted within 8 cycles");
        end
        req_tx_d[1*NB +: NB] = 8'h3C;
        req_tx_dv            = 4'b0110;
        for (int c = 0; c < 200; c++) begin
            #4;
            n_tests++;
            if (b_grant !== 4'b0100 || b_uart_tx_dv !== 1'b1 || b_uart_tx_d !== 8'hA5
                || b_req_tx_dr !== 4'd0 || b_timeout_evt !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_c%0d: grant %b dv %b d %h dr %b evt %b required 0100 1 a5 0000 0",
                         c, b_grant, b_uart_tx_dv, b_uart_tx_d, b_req_tx_dr, b_timeout_evt);
            end
            @(posedge clk);
            #1;
        end
        uart_tx_dr = 1'b1;
        #4;
        n_tests++;
        if (b_req_tx_dr !== 4'b0100) begin
            n_fail++;
            $display("FAIL stall_ready: req_tx_dr %b required 0100", b_req_tx_dr);
        end
        @(posedge clk);
        #1;
        req_tx_dv = '0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        max_busy = 0;
        gap_en   = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        test_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
